// File: rtl/dected_load_ctrl.sv
// DECTED load-path sequencer: read, capture, check, retry on triple error,
// scrub corrected words and respond to the processor with a PC stall.
module dected_load_ctrl #(
  parameter int ADDR_W    = 10,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 16,
  parameter int SCRUB_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  input  logic [15:0]       mem_rd_parity,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  output logic [31:0]       dec_data,
  output logic [15:0]       dec_parity,
  input  logic [31:0]       dec_corrected,
  input  logic              dec_triple,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_corrected,
  output logic              resp_error,
  output logic              stall,
  output logic              fault,
  output logic [CNT_W-1:0]  corr_count,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_CHECK,
    S_SCRUB,
    S_RESP
  } state_t;

  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);
  localparam logic SCRUB_ON = (SCRUB_EN != 0);

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        retry_q;
  logic [31:0]       raw_d;
  logic [15:0]       raw_p;
  logic [31:0]       rdata_q;
  logic              rcorr_q;
  logic              rerr_q;
  logic              fault_q;
  logic [CNT_W-1:0]  corr_q;
  logic [CNT_W-1:0]  err_q;

  logic retry_left;
  logic corr_diff;
  logic triple_retry;
  logic triple_fail;
  logic good_scrub;
  logic good_plain;

  assign retry_left   = (retry_q < MAX_R);
  assign corr_diff    = (dec_corrected != raw_d);
  assign triple_retry = dec_triple && retry_left;
  assign triple_fail  = dec_triple && !retry_left;
  assign good_scrub   = !dec_triple && corr_diff && SCRUB_ON;
  assign good_plain   = !dec_triple && !good_scrub;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_READ;
        end
      end
      S_READ:  state_d = S_CAPT;
      S_CAPT:  state_d = S_CHECK;
      S_CHECK: begin
        unique case (1'b1)
          triple_retry: state_d = S_READ;
          triple_fail:  state_d = S_RESP;
          good_scrub:   state_d = S_SCRUB;
          good_plain:   state_d = S_RESP;
          default:      state_d = S_RESP;
        endcase
      end
      S_SCRUB: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs; address and write data are zero outside their strobes
  always_comb begin
    req_ready   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    stall       = 1'b0;
    resp_valid  = 1'b0;
    unique case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_READ: begin
        mem_rd_en = 1'b1;
        mem_addr  = addr_q;
        stall     = 1'b1;
      end
      S_CAPT:  stall = 1'b1;
      S_CHECK: stall = 1'b1;
      S_SCRUB: begin
        mem_wr_en   = 1'b1;
        mem_addr    = addr_q;
        mem_wr_data = rdata_q;
        stall       = 1'b1;
      end
      S_RESP:  resp_valid = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

  // Request latch and retry counter
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      retry_q <= '0;
    end else if (state_q == S_IDLE && req_valid) begin
      addr_q  <= req_addr;
      retry_q <= '0;
    end else if (state_q == S_CHECK && triple_retry) begin
      retry_q <= retry_q + 3'd1;
    end
  end

  // Capture register feeding the decoder
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_d <= '0;
      raw_p <= '0;
    end else if (state_q == S_CAPT) begin
      raw_d <= mem_rd_data;
      raw_p <= mem_rd_parity;
    end
  end

  // Response registers; a retry pass leaves them untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      rcorr_q <= 1'b0;
      rerr_q  <= 1'b0;
    end else if (state_q == S_CHECK) begin
      if (triple_fail) begin
        rcorr_q <= 1'b0;
        rerr_q  <= 1'b1;
      end else if (!dec_triple) begin
        rdata_q <= dec_corrected;
        rcorr_q <= corr_diff;
        rerr_q  <= 1'b0;
      end
    end
  end

  // Sticky fault and saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
      corr_q  <= '0;
      err_q   <= '0;
    end else if (state_q == S_CHECK) begin
      if (dec_triple && err_q != '1) begin
        err_q <= err_q + CNT_W'(1);
      end
      if (triple_fail) begin
        fault_q <= 1'b1;
      end
      if (!dec_triple && corr_diff && corr_q != '1) begin
        corr_q <= corr_q + CNT_W'(1);
      end
    end
  end

  assign dec_data       = raw_d;
  assign dec_parity     = raw_p;
  assign resp_data      = rdata_q;
  assign resp_corrected = rcorr_q;
  assign resp_error     = rerr_q;
  assign fault          = fault_q;
  assign corr_count     = corr_q;
  assign err_count      = err_q;

endmodule

// File: doc/dected_load_ctrl.md
# dected_load_ctrl

Sequencing controller for the DECTED-protected load path. It accepts one load request at a time and reads the 32-bit data word and its 16 check bits from the cache array. It passes them through the external combinational DECTED decoder and retries on uncorrectable (triple) errors. Corrected single and double errors are scrubbed back to the array, and the processor receives a response plus a stall signal that freezes the PC while a load is in flight.

## Interface
Parameters:
- ADDR_W, 10, cache word-address width
- MAX_RETRY, 2, re-reads allowed after a triple error before the load is declared failed (0 to 7)
- CNT_W, 16, width of the statistics counters
- SCRUB_EN, 1, 1 = write corrected words back to the array; 0 = never write

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  load request
- req_addr  in  ADDR_W  load word address
- req_ready  out  1  controller can accept a request (high only in IDLE)
- mem_rd_en  out  1  array read strobe
- mem_addr  out  ADDR_W  array address for read and scrub write
- mem_rd_data  in  32  array data, valid the cycle after mem_rd_en
- mem_rd_parity  in  16  array check bits, valid the cycle after mem_rd_en
- mem_wr_en  out  1  scrub write strobe; an external encoder regenerates the check bits
- mem_wr_data  out  32  scrub write data
- dec_data  out  32  decoder data input, from the capture register
- dec_parity  out  16  decoder check-bit input, from the capture register
- dec_corrected  in  32  decoder corrected data, combinational
- dec_triple  in  1  decoder uncorrectable flag, combinational
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  32  corrected load data
- resp_corrected  out  1  response data differed from the raw word
- resp_error  out  1  uncorrectable after all retries; resp_data is undefined
- stall  out  1  freeze the PC
- fault  out  1  sticky; set on any failed load, cleared only by rst
- corr_count  out  CNT_W  saturating count of corrected loads
- err_count  out  CNT_W  saturating count of triple detections, one per attempt

## Operation
- The state machine has six states: IDLE, READ, CAPT, CHECK, SCRUB, RESP.
- **IDLE.** req_ready=1. When req_valid=1, latch req_addr, clear the retry counter and go to READ.
- **READ.** mem_rd_en=1 and mem_addr=latched address, for one cycle. Go to CAPT.
- **CAPT.** Register mem_rd_data and mem_rd_parity into raw_d/raw_p. Go to CHECK.
- **CHECK.** dec_data=raw_d and dec_parity=raw_p. Evaluate the decoder outputs:
  - dec_triple=1 and retry < MAX_RETRY: increment err_count and retry, go to READ.
  - dec_triple=1 and retry = MAX_RETRY: increment err_count, set fault, set resp_error, go to RESP.
  - dec_corrected != raw_d: latch dec_corrected, set resp_corrected and increment corr_count. Go to SCRUB if SCRUB_EN, otherwise RESP.
  - otherwise: latch dec_corrected and go to RESP.
- **SCRUB.** mem_wr_en=1, mem_addr=latched address, mem_wr_data=latched corrected word, for one cycle. Go to RESP.
- **RESP.** resp_valid=1 with resp_data, resp_corrected and resp_error stable. Go to IDLE.
- stall=1 in READ, CAPT, CHECK and SCRUB, and 0 in IDLE and RESP.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- Counters saturate at all-ones and never wrap.
- resp_* registers hold their values until the next CHECK. Only resp_valid marks them valid.
- A req_valid outside IDLE is ignored; it is not queued.

## Timing
- Reset values: state IDLE, req_ready=1. Every other output is 0: mem_rd_en, mem_wr_en, mem_addr, mem_wr_data, resp_*, stall, fault, both counters and the dec_* outputs.
- rst in any state, including mid-SCRUB, wins that cycle. The cycle after rst is sampled, no write is issued and all outputs are at reset values.
- Latency is counted from the accept edge T:
  - clean load: resp_valid at T+4.
  - corrected load with SCRUB_EN=1: mem_wr_en at T+4, resp_valid at T+5.
- Each retry adds 3 cycles. With the default MAX_RETRY=2, a failed load responds at T+10.
- The earliest next accept is in the cycle after resp_valid.

## Test plan
- Clean word, addr 0x005, data 0x12345678 with correct check bits → mem_rd_en at T+1, resp_valid at T+4 with data 0x12345678. resp_corrected=0, mem_wr_en never asserted, stall high for exactly 3 cycles.
- Decoder returns 0x12345679 for raw 0x12345678 with SCRUB_EN=1 → mem_wr_en at T+4 with data 0x12345679 at addr 0x005. resp_valid at T+5 with resp_corrected=1, corr_count=1.
- dec_triple=1 on every attempt, MAX_RETRY=2 → 3 mem_rd_en pulses, err_count=3, resp_valid at T+10 with resp_error=1, fault=1 and held after a later clean load.
- dec_triple=1 on the first attempt, clean on the second → 2 reads, err_count=1, resp_error=0, resp_valid at T+7.
- rst asserted during SCRUB → no mem_wr_en after rst is sampled, next-cycle state IDLE, counters 0. A new request then completes normally.
- corr_count preloaded to all-ones (or CNT_W=2 with 5 corrected loads) → saturates at 3 and does not wrap. req_valid held high during a load → exactly one response per accept.
